// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Write-back queue in front of the register file's single write port.
// Two producers (data-memory load path and ALU path) push {addr, data}
// entries into an in-order FIFO; one entry per cycle is drained onto the
// register file's IN / INADDRESS / WRITE pins. A per-register pending mask
// lets decode/stall logic detect RAW hazards on values still in flight.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   DATA_W  write data width
//   ADDR_W  register address width (2**ADDR_W registers)
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RESET_N    asynchronous active-low reset
//   MEM_VALID  load result request            MEM_READY  load accepted when VALID&READY
//   MEM_ADDR   load destination register
//   MEM_DATA   load data
//   ALU_VALID  ALU result request             ALU_READY  ALU accepted when VALID&READY
//   ALU_ADDR   ALU destination register
//   ALU_DATA   ALU result
//   HOLD       freeze draining
//   WB_WRITE   register file WRITE
//   WB_ADDR    register file INADDRESS
//   WB_DATA    register file IN
//   PENDING    bit i set while any queued or presented write targets register i
//   COUNT      current FIFO occupancy
//
// Build option
//   WB_BYPASS_EN  when defined, a request arriving at an empty, non-held
//                 queue is loaded straight into the WB_* registers.
// ---------------------------------------------------------------------------
module reg_writeback #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      MEM_VALID,
    input  logic [ADDR_W-1:0]         MEM_ADDR,
    input  logic [DATA_W-1:0]         MEM_DATA,
    output logic                      MEM_READY,
    input  logic                      ALU_VALID,
    input  logic [ADDR_W-1:0]         ALU_ADDR,
    input  logic [DATA_W-1:0]         ALU_DATA,
    output logic                      ALU_READY,
    input  logic                      HOLD,
    output logic                      WB_WRITE,
    output logic [ADDR_W-1:0]         WB_ADDR,
    output logic [DATA_W-1:0]         WB_DATA,
    output logic [(1<<ADDR_W)-1:0]    PENDING,
    output logic [$clog2(DEPTH):0]    COUNT
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NREG = 1 << ADDR_W;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_CX = (CW+1)'(DEPTH);

    // Storage and pointers
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    // Handshake / control
    logic              mem_acc;
    logic              alu_acc;
    logic              pop;
    logic              bypass;
    logic [CW:0]       occ_plus_mem;

    // Up to two entries written per edge, packed to the front
    logic              e0_v;
    logic [ADDR_W-1:0] e0_addr;
    logic [DATA_W-1:0] e0_data;
    logic              e1_v;
    logic [1:0]        n_push;

    // First accepted request this edge (MEM has priority)
    logic [ADDR_W-1:0] lead_addr;
    logic [DATA_W-1:0] lead_data;

    logic [NREG-1:0]   pend;

    // Ready is based on pre-edge occupancy only; a coincident pop is not credited.
    assign occ_plus_mem = {1'b0, count} + (CW+1)'(MEM_VALID);
    assign MEM_READY    = (count < DEPTH_C);
    assign ALU_READY    = (occ_plus_mem < DEPTH_CX);

    assign mem_acc = MEM_VALID && MEM_READY;
    assign alu_acc = ALU_VALID && ALU_READY;
    assign pop     = (count != '0) && !HOLD;

`ifdef WB_BYPASS_EN
    // Only possible when the queue is empty, so it never competes with pop.
    assign bypass = (count == '0) && !HOLD && (mem_acc || alu_acc);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        lead_addr = mem_acc ? MEM_ADDR : ALU_ADDR;
        lead_data = mem_acc ? MEM_DATA : ALU_DATA;
        if (bypass) begin
            // Lead request goes straight to WB_*; only a trailing ALU entry is queued.
            e0_v    = mem_acc && alu_acc;
            e0_addr = ALU_ADDR;
            e0_data = ALU_DATA;
            e1_v    = 1'b0;
        end else begin
            e0_v    = mem_acc || alu_acc;
            e0_addr = lead_addr;
            e0_data = lead_data;
            e1_v    = mem_acc && alu_acc;
        end
        n_push = {1'b0, e0_v} + {1'b0, e1_v};
    end

    // Entry storage needs no reset: validity is tracked by count/pointers.
    always_ff @(posedge CLK) begin
        if (e0_v) begin
            addr_q[wr_ptr] <= e0_addr;
            data_q[wr_ptr] <= e0_data;
        end
        if (e1_v) begin
            addr_q[wr_ptr + PW'(1)] <= ALU_ADDR;
            data_q[wr_ptr + PW'(1)] <= ALU_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WB_WRITE <= 1'b0;
            WB_ADDR  <= '0;
            WB_DATA  <= '0;
        end else if (pop) begin
            WB_WRITE <= 1'b1;
            WB_ADDR  <= addr_q[rd_ptr];
            WB_DATA  <= data_q[rd_ptr];
        end else if (bypass) begin
            WB_WRITE <= 1'b1;
            WB_ADDR  <= lead_addr;
            WB_DATA  <= lead_data;
        end else begin
            WB_WRITE <= 1'b0;
        end
    end

    // Pending mask: every live FIFO slot plus the write currently presented.
    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                pend[addr_q[rd_ptr + PW'(i)]] = 1'b1;
            end
        end
        if (WB_WRITE) begin
            pend[WB_ADDR] = 1'b1;
        end
    end

    assign PENDING = pend;
    assign COUNT   = count;

endmodule
